latch2_driver: RTL
==================

Name: latch2_driver

Overview:
- Initiator side of the edge-triggered set/clear latch (latch2). Latch2 acts only on rising edges of its set and clear lines, with clear dominant.
- For each of W bits, this block turns a one-cycle set or clear request into a well-formed strobe on o_set/o_clear.
- It holds the strobe until the latch output, fed back on i_fb, confirms the change, then guarantees a low gap so the next request produces a fresh rising edge.
- It reports completion, timeout and dropped requests per bit. It sits between control-unit sequencing logic and the latch2 instances.

Parameters:
- W, 1, number of independent bits/channels.
- PW, 1, minimum cycles o_set/o_clear stays high per strobe (>=1).
- TMO, 15, maximum cycles in a strobe state before timeout (>PW).

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_req_set  in  W  one-cycle request: set bit i.
- i_req_clear  in  W  one-cycle request: clear bit i.
- i_fb  in  W  observed latch output (latch2 o_out).
- o_set  out  W  set strobe to latch, registered.
- o_clear  out  W  clear strobe to latch, registered.
- o_busy  out  W  bit i sequence in progress (not IDLE).
- o_done  out  W  one-cycle pulse: bit i strobe confirmed.
- o_tmo  out  W  one-cycle pulse: bit i strobe timed out.
- o_drop  out  W  one-cycle pulse: request on bit i ignored (busy).

Behaviour:
- Reset: i_rst_n low at a clock edge sets every bit to IDLE, all outputs 0 and counters 0.
  - Reset mid-strobe drops o_set/o_clear at that edge; no o_done or o_tmo is issued.
- Each bit runs an independent FSM with states IDLE, SET, CLR, GAP. All outputs are registered.
- IDLE, on a request sampled at edge t:
  - i_req_clear=1 goes to CLR; o_clear=1 from t+1. Clear wins if both requests are high, matching latch2 priority.
  - i_req_set=1 and i_req_clear=0 goes to SET; o_set=1 from t+1.
  - No request: stay in IDLE.
  - A request is issued even if i_fb already holds the target value. Confirmation then occurs after PW cycles.
- SET:
  - o_set=1 and the cycle counter increments each cycle; the counter is width clog2(TMO+1) and saturates.
  - When count>=PW and i_fb[i]=1, go to GAP with o_done pulsing in the GAP cycle.
  - Otherwise, when count reaches TMO, go to GAP with o_tmo pulsing in the GAP cycle.
- CLR: same as SET, using o_clear and the condition i_fb[i]=0.
- GAP:
  - Exactly 1 cycle with o_set=o_clear=0, o_busy=1.
  - Then IDLE, clearing the counter.
- Requests while o_busy[i]=1, including in GAP:
  - Ignored; o_drop[i] pulses the next cycle.
  - Requests on other bits are unaffected.
- Loopback latency to latch2 with PW=1:
  - Request at t: o_set high t+1..t+2.
  - GAP/o_done at t+3, IDLE at t+4.
  - Earliest next request is accepted at t+4, with its strobe at t+5.
- o_set and o_clear of one bit are never high in the same cycle.
- o_done and o_tmo are mutually exclusive.
- Timeout path: the strobe is held for TMO cycles, then GAP. The bit returns to IDLE with no retry; i_fb is left as observed.
- i_fb changing during GAP/IDLE is ignored.

Decomposition:
- Shared package latch2_pkg holds:
  - the state enum (IDLE, SET, CLR, GAP, 2-bit encoding);
  - the counter-width function clog2.
- Sub-module latch2_driver_bit holds the single-bit FSM, counter and pulse outputs. Its parameters are PW and TMO.
- The top instantiates W copies of latch2_driver_bit in a generate loop and does no cross-bit logic.

Test Plan:
- Loopback to latch2, W=1, PW=1: i_req_set pulse at t0 -> o_set high t0+1..t0+2, latch out=1 at t0+2, o_done at t0+3, o_busy low at t0+4. Then i_req_clear -> same timing on o_clear, i_fb returns to 0.
- Simultaneous i_req_set=1 and i_req_clear=1 in IDLE -> only o_clear strobes, o_set stays 0, o_done after i_fb=0.
- i_fb tied 0, set request, TMO=15 -> o_set high exactly 15 cycles, then GAP with o_tmo=1, o_done=0, then IDLE.
- Set request in cycles t0 and t0+1 -> second request yields o_drop at t0+2 and no extra strobe. A request at t0+4 is accepted and o_set re-rises after the 1-cycle gap, so latch2 sees a new edge.
- i_rst_n low while o_set high -> o_set=0, o_busy=0 at that edge, no o_done/o_tmo. Normal operation resumes after release.
- W=4, independent requests on bits 0 and 3 in the same cycle with PW=3 -> each strobe holds >=3 cycles. Bit 3 delayed-ack (i_fb forced late by 5 cycles) completes later, and bit 0 o_done timing is unaffected.

Source files
------------

// File: rtl/latch2_pkg.sv
// Shared types and helpers for the latch2 strobe driver.
package latch2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SET  = 2'd1,
    ST_CLR  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/latch2_driver_bit.sv
// One channel of the latch2 driver: strobe, wait for feedback or timeout, gap.
//
// state | meaning
// IDLE  | waiting for a set/clear request
// SET   | o_set high, waiting for i_fb=1
// CLR   | o_clear high, waiting for i_fb=0
// GAP   | one low cycle so the next strobe is a fresh rising edge
module latch2_driver_bit
  import latch2_pkg::*;
#(
  parameter int PW  = 1,
  parameter int TMO = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_set,
  input  logic i_req_clear,
  input  logic i_fb,
  output logic o_set,
  output logic o_clear,
  output logic o_busy,
  output logic o_done,
  output logic o_tmo,
  output logic o_drop
);

  localparam int CW = clog2(TMO + 1);
  localparam logic [CW-1:0] PW_C  = CW'(PW);
  localparam logic [CW-1:0] TMO_C = CW'(TMO);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          set_q, set_d;
  logic          clear_q, clear_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tmo_q, tmo_d;
  logic          drop_q, drop_d;
  logic          hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    hit     = 1'b0;
    drop_d  = (state_q != ST_IDLE) && (i_req_set || i_req_clear);
    case (state_q)
      ST_IDLE: begin
        // clear dominates, matching the latch's own priority
        if (i_req_clear) begin
          state_d = ST_CLR;
          cnt_d   = ONE_C;
        end else if (i_req_set) begin
          state_d = ST_SET;
          cnt_d   = ONE_C;
        end
      end
      ST_SET, ST_CLR: begin
        hit = (state_q == ST_SET) ? i_fb : ~i_fb;
        if ((cnt_q >= PW_C) && hit) begin
          state_d = ST_GAP;
          done_d  = 1'b1;
        end else if (cnt_q >= TMO_C) begin
          state_d = ST_GAP;
          tmo_d   = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    set_d   = (state_d == ST_SET);
    clear_d = (state_d == ST_CLR);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      set_q   <= 1'b0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
      clear_q <= clear_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      drop_q  <= drop_d;
    end
  end

  assign o_set   = set_q;
  assign o_clear = clear_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_tmo   = tmo_q;
  assign o_drop  = drop_q;

endmodule

// File: rtl/latch2_driver.sv
// W independent strobe drivers for latch2 set/clear inputs.
module latch2_driver #(
  parameter int W   = 1,
  parameter int PW  = 1,
  parameter int TMO = 15
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_req_set,
  input  logic [W-1:0] i_req_clear,
  input  logic [W-1:0] i_fb,
  output logic [W-1:0] o_set,
  output logic [W-1:0] o_clear,
  output logic [W-1:0] o_busy,
  output logic [W-1:0] o_done,
  output logic [W-1:0] o_tmo,
  output logic [W-1:0] o_drop
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    latch2_driver_bit #(
      .PW (PW),
      .TMO(TMO)
    ) u_bit (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_req_set  (i_req_set[i]),
      .i_req_clear(i_req_clear[i]),
      .i_fb       (i_fb[i]),
      .o_set      (o_set[i]),
      .o_clear    (o_clear[i]),
      .o_busy     (o_busy[i]),
      .o_done     (o_done[i]),
      .o_tmo      (o_tmo[i]),
      .o_drop     (o_drop[i])
    );
  end

endmodule
